// File: rtl/led_scan_pkg.sv
// rtl/led_scan_pkg.sv - shared state encoding and counter sizing for the LED column scanner
package led_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } scan_state_t;

  // Counter must hold 0..max(dwell, blank)-1; never narrower than one bit.
  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_scan_controller_dwell_timer.sv
// rtl/led_scan_controller_dwell_timer.sv - loadable terminal-count counter (dwell_timer)
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         done
);

  logic [W-1:0] term;

  // Load restarts from zero with a new terminal value; clear only zeroes the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      term  <= '0;
    end else if (load) begin
      count <= '0;
      term  <= limit;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign done = (count == term);

endmodule

// File: rtl/led_scan_controller.sv
// rtl/led_scan_controller.sv - column scan sequencer with double-buffered frames; LED_SCAN_BRIGHTNESS_EN enables dwell dimming
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int N            = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int BRIGHT_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_en,
  input  logic [N*N-1:0]      frame_in,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic                ena,
  output logic [$clog2(N):0]  x,
  output logic [N*N-1:0]      cells,
  output logic                frame_start
);

  localparam int XW = $clog2(N) + 1;
  localparam int CW = cnt_width(DWELL_CYCLES, BLANK_CYCLES);

  if (N < 1 || N > 8) begin : g_bad_n
    $error("led_scan_controller: N must be 1..8");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("led_scan_controller: DWELL_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("led_scan_controller: BLANK_CYCLES must be >= 1");
  end

  scan_state_t    state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt, limit;
  logic           done, load, clear, start, adv, last_col, boundary, on_lit;
  logic [N*N-1:0] pending;
  logic           pending_full;

  dwell_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .load  (load),
    .limit (limit),
    .count (cnt),
    .done  (done)
  );

  assign last_col = (x == XW'(N - 1));
  assign boundary = start | (adv & last_col);
  assign cnt_nxt  = (load | clear) ? '0 : cnt + CW'(1);

`ifdef LED_SCAN_BRIGHTNESS_EN
  // Full-width product so the threshold is exact before the shift.
  localparam int PW = CW + BRIGHT_W + 1;
  logic [PW-1:0] prod, thr;
  assign prod   = PW'(DWELL_CYCLES) * PW'(brightness);
  assign thr    = prod >> BRIGHT_W;
  assign on_lit = (PW'(cnt_nxt) < thr);
`else
  logic unused_bright;
  assign unused_bright = ^brightness;
  assign on_lit        = 1'b1;
`endif

  // Next-state decode; scan_en low always forces idle, even mid-column.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear     = 1'b0;
    start     = 1'b0;
    adv       = 1'b0;
    limit     = CW'(BLANK_CYCLES - 1);
    if (!scan_en) begin
      state_nxt = S_IDLE;
      clear     = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_BLANK;
          load      = 1'b1;
          start     = 1'b1;
        end
        S_BLANK: begin
          if (done) begin
            state_nxt = S_ON;
            load      = 1'b1;
            limit     = CW'(DWELL_CYCLES - 1);
          end
        end
        S_ON: begin
          if (done) begin
            state_nxt = S_BLANK;
            load      = 1'b1;
            adv       = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          clear     = 1'b1;
        end
      endcase
    end
  end

  // State, registered enable, column index and frame double buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ena          <= 1'b0;
      x            <= '0;
      cells        <= '0;
      frame_start  <= 1'b0;
      pending      <= '0;
      pending_full <= 1'b0;
      frame_ready  <= 1'b1;
    end else begin
      state       <= state_nxt;
      ena         <= (state_nxt == S_ON) && on_lit;
      frame_start <= boundary;
      if (start || (adv && last_col)) begin
        x <= '0;
      end else if (adv) begin
        x <= x + XW'(1);
      end
      // Swap needs a full buffer and transfer needs an empty one, so they never collide.
      if (boundary && pending_full) begin
        cells        <= pending;
        pending_full <= 1'b0;
        frame_ready  <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        pending      <= frame_in;
        pending_full <= 1'b1;
        frame_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_controller.sv
// tb/tb_led_scan_controller.sv - randomized bench for led_scan_controller against a time-based reference model
module tb_led_scan_controller;

  localparam int N     = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int BW    = 4;
  localparam int P     = DWELL + BLANK;
  localparam int FP    = N * P;

  logic          clk = 1'b0;
  logic          rst_n, scan_en, frame_valid, frame_ready, ena, frame_start;
  logic [63:0]   frame_in, cells;
  logic [BW-1:0] brightness;
  logic [3:0]    x;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: elapsed cycles since scan start determine column and phase.
  bit          m_run, m_pfull, m_ena, m_fs;
  int          t;
  logic [3:0]  m_x;
  logic [63:0] m_cells, m_pend;

  led_scan_controller #(
    .N(N), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK), .BRIGHT_W(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .frame_in(frame_in),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .brightness(brightness),
    .ena(ena), .x(x), .cells(cells), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit ready_pre, bnd;
    int thr, ph;
    ready_pre = !m_pfull;
    bnd       = 1'b0;
    m_fs      = 1'b0;
    if (!rst_n) begin
      m_run = 0; t = 0; m_x = 0; m_cells = 0; m_pend = 0; m_pfull = 0; m_ena = 0;
      return;
    end
    if (!scan_en) m_run = 0;
    else if (!m_run) begin m_run = 1; t = 0; bnd = 1; end
    else begin t++; if (t % FP == 0) bnd = 1; end
    if (m_run) m_x = 4'((t / P) % N);
`ifdef LED_SCAN_BRIGHTNESS_EN
    thr = (DWELL * int'(brightness)) >> BW;
`else
    thr = DWELL;
`endif
    ph    = t % P;
    m_ena = m_run && (ph >= BLANK) && ((ph - BLANK) < thr);
    if (bnd) begin
      m_fs = 1;
      if (m_pfull) begin m_cells = m_pend; m_pfull = 0; end
    end
    if (frame_valid && ready_pre) begin m_pend = frame_in; m_pfull = 1; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("ena", ena, m_ena);
    check("x", x, m_x);
    check("cells", cells, m_cells);
    check("frame_ready", frame_ready, !m_pfull);
    check("frame_start", frame_start, m_fs);
  endtask

  initial begin
    rst_n = 0; scan_en = 0; frame_valid = 0; frame_in = '0; brightness = 4'd8;
    repeat (3) tick();
    check("rst_ena", ena, 0);
    check("rst_x", x, 0);
    check("rst_cells", cells, 0);
    check("rst_ready", frame_ready, 1);
    check("rst_fs", frame_start, 0);
    rst_n = 1;
    tick();

    // Scan start, frame offered in column 3, second frame held under back-pressure.
    scan_en = 1;
    tick();
    check("first_fs", frame_start, 1);
    check("first_ena", ena, 0);
    repeat (18) tick();
    check("col3_x", x, 3);
    frame_valid = 1; frame_in = 64'hA5;
    tick();
    check("ready_drop", frame_ready, 0);
    frame_in = 64'h3C;
    repeat (28) tick();
    check("old_frame", cells, 0);
    check("bp_ready", frame_ready, 0);
    tick();
    check("swap_a5", cells, 64'hA5);
    check("wrap_x", x, 0);
    check("wrap_fs", frame_start, 1);
    check("ready_rise", frame_ready, 1);
    tick();
    check("bp_accept", frame_ready, 0);
    frame_valid = 0;
    repeat (47) tick();
    check("swap_3c", cells, 64'h3C);

    // Abort mid-dwell at column 5, then restart.
    repeat (33) tick();
    check("pre_abort_x", x, 5);
    scan_en = 0;
    tick();
    check("abort_ena", ena, 0);
    check("abort_x", x, 5);
    repeat (3) tick();
    scan_en = 1;
    tick();
    check("restart_x", x, 0);
    check("restart_fs", frame_start, 1);

    // Random traffic with occasional aborts and resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 799) != 0);
      scan_en     = ($urandom_range(0, 149) != 0);
      frame_valid = ($urandom_range(0, 9) == 0);
      frame_in    = {$urandom, $urandom};
      brightness  = BW'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
